// File: rtl/matrix_pkg.sv
// Shared constants, scale-slot mapping and FSM encodings for the matrix storage path.
package matrix_pkg;

    localparam int unsigned MAX_DIM    = 5;
    localparam int unsigned NUM_SCALES = MAX_DIM * MAX_DIM;
    // The flat read bus always carries 25 elements, independent of the query scale.
    localparam int unsigned NUM_ELEMS  = 25;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    // Row-major scale slot: (row-1)*MAX_DIM + (col-1), range 0..24 for legal dims.
    function automatic logic [4:0] scale_slot(input logic [2:0] row, input logic [2:0] col);
        return 5'(5'(row - 3'd1) * 5'(MAX_DIM) + 5'(col - 3'd1));
    endfunction

    function automatic logic dims_legal(input logic [2:0] row, input logic [2:0] col,
                                        input int unsigned max_dim);
        return (row != 3'd0) && (col != 3'd0) &&
               (32'(row) <= max_dim) && (32'(col) <= max_dim);
    endfunction

endpackage

// File: rtl/matrix_scale_storage_if.sv
// Write stream and polled read port between parser, storage and displayer.
interface matrix_scale_storage_if
#(
    parameter int unsigned DATA_WIDTH = 9
) ();
    import matrix_pkg::*;

    logic                            wr_start;
    logic [2:0]                      wr_row;
    logic [2:0]                      wr_col;
    logic                            wr_valid;
    logic [DATA_WIDTH-1:0]           wr_data;
    logic                            wr_ready;
    logic                            wr_done;
    logic                            wr_err;
    logic [2:0]                      req_scale_row;
    logic [2:0]                      req_scale_col;
    logic [2:0]                      req_idx;
    logic [2:0]                      scale_matrix_cnt;
    logic [NUM_ELEMS*DATA_WIDTH-1:0] read_data;
    logic                            read_valid;

    modport master (
        output wr_start, wr_row, wr_col, wr_valid, wr_data,
        output req_scale_row, req_scale_col, req_idx,
        input  wr_ready, wr_done, wr_err,
        input  scale_matrix_cnt, read_data, read_valid
    );

    modport slave (
        input  wr_start, wr_row, wr_col, wr_valid, wr_data,
        input  req_scale_row, req_scale_col, req_idx,
        output wr_ready, wr_done, wr_err,
        output scale_matrix_cnt, read_data, read_valid
    );

endinterface

// File: rtl/matrix_slot_addr.sv
// Maps (scale, logical index) onto a physical storage entry; shared by write and read paths.
module matrix_slot_addr
    import matrix_pkg::*;
#(
    parameter int unsigned MAX_PER_SCALE = 2,
    parameter int unsigned MAX_DIM       = 5,
    parameter int unsigned ADDR_W        = $clog2(NUM_SCALES * MAX_PER_SCALE)
) (
    input  logic [2:0]        scale_row,
    input  logic [2:0]        scale_col,
    input  logic [2:0]        idx,
    input  logic              wr_mode,
    input  logic [2:0]        cnt_tab    [NUM_SCALES],
    input  logic [2:0]        oldest_tab [NUM_SCALES],
    output logic              legal,
    output logic [2:0]        cnt,
    output logic [ADDR_W-1:0] addr,
    output logic              valid
);

    logic [4:0] scale;
    logic [2:0] oldest;
    logic [2:0] eff_idx;
    logic [3:0] sum;
    logic [2:0] phys;

    // Write mode uses idx=count: (oldest+count) mod N is count while filling, oldest when full.
    always_comb begin
        legal   = dims_legal(scale_row, scale_col, MAX_DIM);
        scale   = legal ? scale_slot(scale_row, scale_col) : 5'd0;
        cnt     = legal ? cnt_tab[scale] : 3'd0;
        oldest  = legal ? oldest_tab[scale] : 3'd0;
        eff_idx = wr_mode ? cnt : idx;
        sum     = {1'b0, oldest} + {1'b0, eff_idx};
        phys    = 3'(sum % 4'(MAX_PER_SCALE));
        valid   = legal && (idx < cnt);
        addr    = ADDR_W'(scale) * ADDR_W'(MAX_PER_SCALE) + ADDR_W'(phys);
    end

endmodule

// File: rtl/matrix_scale_storage.sv
// Per-scale round-robin matrix store fed by a row-major element stream.
module matrix_scale_storage
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 9,
    parameter int unsigned MAX_PER_SCALE = 2,
    parameter int unsigned MAX_DIM       = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    matrix_scale_storage_if.slave bus
);

    localparam int unsigned FLAT_W      = NUM_ELEMS * DATA_WIDTH;
    localparam int unsigned NUM_ENTRIES = NUM_SCALES * MAX_PER_SCALE;
    localparam int unsigned ADDR_W      = $clog2(NUM_ENTRIES);

    logic [1:0]            state;
    logic [2:0]            row_q;
    logic [2:0]            col_q;
    logic [4:0]            elem_cnt;
    logic [4:0]            elem_last;
    logic [4:0]            wr_scale;
    logic                  start_ok;
    logic                  accept;
    logic [DATA_WIDTH-1:0] staging    [NUM_ELEMS];
    logic [FLAT_W-1:0]     stage_flat;
    logic [FLAT_W-1:0]     mem        [NUM_ENTRIES];
    logic [2:0]            cnt_tab    [NUM_SCALES];
    logic [2:0]            oldest_tab [NUM_SCALES];

    logic [2:0]            wr_cnt;
    logic [ADDR_W-1:0]     wr_addr;
    logic                  wr_unused_legal;
    logic                  wr_unused_valid;
    logic [2:0]            rd_cnt;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  rd_legal;
    logic                  rd_valid;

    assign start_ok     = bus.wr_start && dims_legal(bus.wr_row, bus.wr_col, MAX_DIM);
    assign accept       = bus.wr_valid && (state == FILL);
    assign elem_last    = 5'(row_q) * 5'(col_q) - 5'd1;
    assign wr_scale     = scale_slot(row_q, col_q);
    assign bus.wr_ready = (state == FILL);

    matrix_slot_addr #(
        .MAX_PER_SCALE (MAX_PER_SCALE),
        .MAX_DIM       (MAX_DIM),
        .ADDR_W        (ADDR_W)
    ) u_wr_addr (
        .scale_row  (row_q),
        .scale_col  (col_q),
        .idx        (3'd0),
        .wr_mode    (1'b1),
        .cnt_tab    (cnt_tab),
        .oldest_tab (oldest_tab),
        .legal      (wr_unused_legal),
        .cnt        (wr_cnt),
        .addr       (wr_addr),
        .valid      (wr_unused_valid)
    );

    matrix_slot_addr #(
        .MAX_PER_SCALE (MAX_PER_SCALE),
        .MAX_DIM       (MAX_DIM),
        .ADDR_W        (ADDR_W)
    ) u_rd_addr (
        .scale_row  (bus.req_scale_row),
        .scale_col  (bus.req_scale_col),
        .idx        (bus.req_idx),
        .wr_mode    (1'b0),
        .cnt_tab    (cnt_tab),
        .oldest_tab (oldest_tab),
        .legal      (rd_legal),
        .cnt        (rd_cnt),
        .addr       (rd_addr),
        .valid      (rd_valid)
    );

    // Control FSM: dimension check, element counting and the one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            elem_cnt    <= '0;
            bus.wr_done <= 1'b0;
            bus.wr_err  <= 1'b0;
        end else begin
            bus.wr_done <= 1'b0;
            bus.wr_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        row_q    <= bus.wr_row;
                        col_q    <= bus.wr_col;
                        elem_cnt <= '0;
                        state    <= FILL;
                    end else if (bus.wr_start) begin
                        bus.wr_err <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        elem_cnt <= elem_cnt + 5'd1;
                        if (elem_cnt == elem_last) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    bus.wr_done <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Staging buffer: cleared on each accepted start so unused tail entries commit as zero.
    always_ff @(posedge clk) begin
        if (!rst_n || (state == IDLE && start_ok)) begin
            for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
                staging[5'(i)] <= '0;
            end
        end else if (accept) begin
            staging[elem_cnt] <= bus.wr_data;
        end
    end

    // Flatten staging into the read-bus layout for a single-cycle commit.
    always_comb begin
        stage_flat = '0;
        for (int unsigned k = 0; k < NUM_ELEMS; k++) begin
            stage_flat[k*DATA_WIDTH +: DATA_WIDTH] = staging[5'(k)];
        end
    end

    // Storage commit plus per-scale count / oldest-pointer bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
            for (int unsigned s = 0; s < NUM_SCALES; s++) begin
                cnt_tab[5'(s)]    <= '0;
                oldest_tab[5'(s)] <= '0;
            end
        end else if (state == COMMIT) begin
            mem[wr_addr] <= stage_flat;
            if (32'(wr_cnt) < MAX_PER_SCALE) begin
                cnt_tab[wr_scale] <= wr_cnt + 3'd1;
            end else if (32'(oldest_tab[wr_scale]) == MAX_PER_SCALE - 1) begin
                oldest_tab[wr_scale] <= 3'd0;
            end else begin
                oldest_tab[wr_scale] <= oldest_tab[wr_scale] + 3'd1;
            end
        end
    end

    // Combinational read port; illegal scale or out-of-range index reads as zero.
    always_comb begin
        bus.scale_matrix_cnt = rd_cnt;
        bus.read_valid       = rd_valid;
        bus.read_data        = rd_valid ? mem[rd_addr] : '0;
    end

endmodule
